// File: rtl/decode_pkg.sv
// decode_pkg: default widths, register index type and immediate sign extension shared by the
// decode_stage_sb slice (optional WB bypass is selected by DECODE_WB_BYPASS_EN in the top).
package decode_pkg;
   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREG  = 32;
   localparam int DEF_AW    = 5;
   localparam int DEF_IMM_W = 16;
   typedef logic [DEF_AW-1:0] reg_idx_t;
   function automatic logic [DEF_XLEN-1:0] sign_extend(input logic [DEF_IMM_W-1:0] imm);
      return {{(DEF_XLEN-DEF_IMM_W){imm[DEF_IMM_W-1]}}, imm};
   endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one busy flag per register; a same-cycle set and clear of one flag leaves it set,
// and flag 0 can never become busy.
module reg_scoreboard import decode_pkg::*; #(
   parameter int NREG = DEF_NREG,
   parameter int AW   = DEF_AW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            set_i,
   input  reg_idx_t        set_addr_i,
   input  logic            clr_i,
   input  reg_idx_t        clr_addr_i,
   output logic [NREG-1:0] busy_o
);
   logic [NREG-1:0] busy_q, busy_d;
   always_comb begin
      busy_d = busy_q;
      if (clr_i) busy_d[clr_addr_i] = 1'b0;
      if (set_i) busy_d[set_addr_i] = 1'b1;
      busy_d[0] = 1'b0;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) busy_q <= '0;
      else busy_q <= busy_d;
   assign busy_o = busy_q;
endmodule

// File: rtl/decode_stage_sb.sv
// decode_stage_sb: ID stage with register file, scoreboard RAW/WAW stall and a registered ID/EX slot.
// Define DECODE_WB_BYPASS_EN to forward wb_data to a source that retires in the same cycle.
module decode_stage_sb import decode_pkg::*; #(
   parameter int XLEN  = DEF_XLEN,
   parameter int NREG  = DEF_NREG,
   parameter int AW    = DEF_AW,
   parameter int IMM_W = DEF_IMM_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_valid,
   output logic             id_ready,
   input  logic [AW-1:0]    inst_rs,
   input  logic [AW-1:0]    inst_rt,
   input  logic [AW-1:0]    inst_rd,
   input  logic [IMM_W-1:0] inst_imm,
   input  logic             reg_dst,
   input  logic             reg_write,
   input  logic             wb_valid,
   input  logic [AW-1:0]    wb_addr,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             ex_ready,
   output logic             id_valid,
   output logic [XLEN-1:0]  id_rs_data,
   output logic [XLEN-1:0]  id_rt_data,
   output logic [IMM_W-1:0] id_imm_raw,
   output logic [XLEN-1:0]  id_sext_imm,
   output logic [XLEN-1:0]  id_imm_shl2,
   output logic [AW-1:0]    id_dst,
   output logic             id_reg_write
);
   logic [NREG-1:0] busy;
   logic [XLEN-1:0] rf_q [NREG];
   logic [AW-1:0] dst, dst_q;
   logic [XLEN-1:0] rs_val, rt_val, rs_q, rt_q;
   logic [IMM_W-1:0] imm_q;
   logic rs_haz, rt_haz, wr_en, hazard, accept, valid_q, rw_q;
   assign dst   = reg_dst ? inst_rd : inst_rt;
   assign wr_en = reg_write & (dst != '0);
`ifdef DECODE_WB_BYPASS_EN
   logic rs_byp, rt_byp;
   assign rs_byp = wb_valid & (wb_addr == inst_rs) & (inst_rs != '0);
   assign rt_byp = wb_valid & (wb_addr == inst_rt) & (inst_rt != '0);
   assign rs_haz = busy[inst_rs] & ~rs_byp;
   assign rt_haz = busy[inst_rt] & ~rt_byp;
   assign rs_val = rs_byp ? wb_data : rf_q[inst_rs];
   assign rt_val = rt_byp ? wb_data : rf_q[inst_rt];
`else
   assign rs_haz = busy[inst_rs];
   assign rt_haz = busy[inst_rt];
   assign rs_val = rf_q[inst_rs];
   assign rt_val = rf_q[inst_rt];
`endif
   // WAW: a writer may not issue while an older write to the same register is in flight
   assign hazard   = if_valid & (rs_haz | rt_haz | (reg_write & busy[dst]));
   assign id_ready = ~hazard & (~valid_q | ex_ready);
   assign accept   = if_valid & id_ready;
   reg_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
      .clk(clk), .reset(reset),
      .set_i(accept & wr_en), .set_addr_i(dst),
      .clr_i(wb_valid), .clr_addr_i(wb_addr),
      .busy_o(busy)
   );
   // Entry 0 is never written, so it reads as zero without a read-side mux
   always_ff @(posedge clk or posedge reset)
      if (reset) for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      else if (wb_valid && wb_addr != '0) rf_q[wb_addr] <= wb_data;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         valid_q <= 1'b0;
         rs_q    <= '0;
         rt_q    <= '0;
         imm_q   <= '0;
         dst_q   <= '0;
         rw_q    <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         rs_q    <= rs_val;
         rt_q    <= rt_val;
         imm_q   <= inst_imm;
         dst_q   <= dst;
         rw_q    <= wr_en;
      end else if (ex_ready) valid_q <= 1'b0;
   assign id_valid     = valid_q;
   assign id_rs_data   = rs_q;
   assign id_rt_data   = rt_q;
   assign id_imm_raw   = imm_q;
   assign id_sext_imm  = sign_extend(imm_q);
   assign id_imm_shl2  = {id_sext_imm[XLEN-3:0], 2'b00};
   assign id_dst       = dst_q;
   assign id_reg_write = rw_q;
endmodule

// File: tb/tb_decode_stage_sb.sv
// tb_decode_stage_sb: directed and random stimulus against a register/scoreboard-level reference model.
module tb_decode_stage_sb;
   logic clk = 1'b0, reset = 1'b1;
   logic if_valid = 0, reg_dst = 0, reg_write = 0, wb_valid = 0, ex_ready = 1;
   logic [4:0] inst_rs = 0, inst_rt = 0, inst_rd = 0, wb_addr = 0;
   logic [15:0] inst_imm = 0;
   logic [31:0] wb_data = 0;
   logic id_ready, id_valid, id_reg_write;
   logic [31:0] id_rs_data, id_rt_data, id_sext_imm, id_imm_shl2;
   logic [15:0] id_imm_raw;
   logic [4:0] id_dst;
   logic sb_set = 0, sb_clr = 0;
   logic [4:0] sb_saddr = 0, sb_caddr = 0;
   logic [31:0] sb_busy;
`ifdef DECODE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   int passed = 0, total = 0;
   bit last_acc;
   bit m_busy [32];
   logic [31:0] m_rf [32];
   logic m_valid, m_rw;
   logic [31:0] m_rs, m_rt;
   logic [15:0] m_imm;
   logic [4:0] m_dst;

   always #5 clk = ~clk;

   decode_stage_sb dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .id_ready(id_ready),
      .inst_rs(inst_rs), .inst_rt(inst_rt), .inst_rd(inst_rd), .inst_imm(inst_imm),
      .reg_dst(reg_dst), .reg_write(reg_write), .wb_valid(wb_valid), .wb_addr(wb_addr),
      .wb_data(wb_data), .ex_ready(ex_ready), .id_valid(id_valid), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_imm_raw(id_imm_raw), .id_sext_imm(id_sext_imm),
      .id_imm_shl2(id_imm_shl2), .id_dst(id_dst), .id_reg_write(id_reg_write)
   );

   reg_scoreboard sb (
      .clk(clk), .reset(reset), .set_i(sb_set), .set_addr_i(sb_saddr),
      .clr_i(sb_clr), .clr_addr_i(sb_caddr), .busy_o(sb_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic mreset();
      foreach (m_busy[i]) begin m_busy[i] = 0; m_rf[i] = 0; end
      m_valid = 0; m_rw = 0; m_rs = 0; m_rt = 0; m_imm = 0; m_dst = 0;
   endtask

   function automatic bit fwd(input logic [4:0] r);
      return BYP && wb_valid && wb_addr == r && r != 0;
   endfunction
   function automatic bit src_busy(input logic [4:0] r);
      return r != 0 && m_busy[r] && !fwd(r);
   endfunction
   function automatic logic [31:0] opnd(input logic [4:0] r);
      return r == 0 ? 32'd0 : fwd(r) ? wb_data : m_rf[r];
   endfunction

   task automatic check_outputs();
      logic [31:0] sext, eb;
      sext = 32'($signed(m_imm));
      for (int i = 0; i < 32; i++) eb[i] = m_busy[i];
      chk("id_valid", 32'(id_valid), 32'(m_valid));
      chk("id_rs_data", id_rs_data, m_rs);
      chk("id_rt_data", id_rt_data, m_rt);
      chk("id_imm_raw", 32'(id_imm_raw), 32'(m_imm));
      chk("id_sext_imm", id_sext_imm, sext);
      chk("id_imm_shl2", id_imm_shl2, sext * 4);
      chk("id_dst", 32'(id_dst), 32'(m_dst));
      chk("id_reg_write", 32'(id_reg_write), 32'(m_rw));
      chk("busy", dut.busy, eb);
   endtask

   // Entered at posedge+1 with inputs applied; returns at the next posedge+1
   task automatic cycle();
      logic [4:0] d;
      bit haz, rdy;
      #3;
      d = reg_dst ? inst_rd : inst_rt;
      haz = if_valid && (src_busy(inst_rs) || src_busy(inst_rt) || (reg_write && d != 0 && m_busy[d]));
      rdy = !haz && (!m_valid || ex_ready);
      last_acc = if_valid && rdy;
      chk("id_ready", 32'(id_ready), 32'(rdy));
      if (last_acc) begin
         m_valid = 1; m_rs = opnd(inst_rs); m_rt = opnd(inst_rt);
         m_imm = inst_imm; m_dst = d; m_rw = reg_write && d != 0;
      end else if (ex_ready) m_valid = 0;
      if (wb_valid) begin
         if (wb_addr != 0) m_rf[wb_addr] = wb_data;
         m_busy[wb_addr] = 0;
      end
      if (last_acc && reg_write && d != 0) m_busy[d] = 1;
      m_busy[0] = 0;
      @(posedge clk); #1;
      check_outputs();
   endtask

   task automatic instr(input logic [4:0] rs, rt, rd, input logic [15:0] imm, input logic rdst, rw);
      if_valid = 1; inst_rs = rs; inst_rt = rt; inst_rd = rd; inst_imm = imm;
      reg_dst = rdst; reg_write = rw;
   endtask

   task automatic idle();
      if_valid = 0; reg_write = 0; wb_valid = 0; ex_ready = 1;
   endtask

   initial begin
      int n, q[$];
      mreset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      reset = 0;
      // accept with negative immediate, rd destination
      instr(1, 2, 3, 16'hFFFC, 1, 1);
      cycle();
      chk("t2_valid", 32'(id_valid), 1);
      chk("t2_dst", 32'(id_dst), 3);
      chk("t2_sext", id_sext_imm, 32'hFFFFFFFC);
      chk("t2_shl2", id_imm_shl2, 32'hFFFFFFF0);
      chk("t2_sb3", 32'(dut.busy[3]), 1);
      // RAW on r3 resolved by writeback
      instr(3, 0, 0, 16'h0001, 1, 0);
      wb_valid = 1; wb_addr = 3; wb_data = 32'h55;
      n = 1;
      cycle();
      wb_valid = 0;
      if (!last_acc) begin n++; cycle(); end
      chk("t3_latency", n, BYP ? 1 : 2);
      chk("t3_rs_data", id_rs_data, 32'h55);
      // back-pressure holds the slot
      instr(3, 3, 0, 16'h1234, 1, 0);
      cycle();
      ex_ready = 0;
      instr(2, 1, 0, 16'h0F0F, 1, 0);
      cycle();
      chk("t4_ready", 32'(id_ready), 0);
      cycle();
      chk("t4_hold", 32'(id_imm_raw), 32'h1234);
      ex_ready = 1;
      cycle();
      chk("t4_load", 32'(id_imm_raw), 32'h0F0F);
      // writes aimed at r0
      instr(0, 0, 0, 16'h0000, 1, 1);
      wb_valid = 1; wb_addr = 0; wb_data = 32'hFF;
      cycle();
      chk("t5_rw", 32'(id_reg_write), 0);
      wb_valid = 0;
      instr(0, 0, 0, 16'h0000, 1, 0);
      cycle();
      chk("t5_r0", id_rs_data, 0);
      // set-wins on the scoreboard itself
      sb_set = 1; sb_saddr = 5;
      @(posedge clk); #1;
      sb_clr = 1; sb_caddr = 5;
      @(posedge clk); #1;
      chk("t6_setwins", 32'(sb_busy[5]), 1);
      sb_set = 0; sb_saddr = 0;
      @(posedge clk); #1;
      chk("t6_clear", sb_busy, 0);
      sb_clr = 0; sb_set = 1;
      @(posedge clk); #1;
      chk("t6_bit0", sb_busy, 0);
      sb_set = 0;
      // random traffic
      for (int k = 0; k < 400; k++) begin
         if_valid = $urandom_range(0, 3) != 0;
         inst_rs = 5'($urandom_range(0, 7)); inst_rt = 5'($urandom_range(0, 7));
         inst_rd = 5'($urandom_range(0, 7)); inst_imm = 16'($urandom);
         reg_dst = 1'($urandom); reg_write = $urandom_range(0, 2) != 0;
         ex_ready = $urandom_range(0, 3) != 0;
         wb_valid = 0;
         q.delete();
         for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
         if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
            wb_valid = 1; wb_addr = 5'(q[$urandom_range(0, q.size() - 1)]); wb_data = $urandom;
         end
         cycle();
      end
      // drain, then async reset while holding a writer to r3
      idle();
      for (int i = 1; i < 32; i++) if (m_busy[i]) begin
         wb_valid = 1; wb_addr = 5'(i); wb_data = $urandom;
         cycle();
      end
      wb_valid = 0;
      instr(1, 2, 3, 16'h8001, 1, 1);
      cycle();
      idle();
      ex_ready = 0;
      cycle();
      chk("t1_pre_valid", 32'(id_valid), 1);
      chk("t1_pre_sb3", 32'(dut.busy[3]), 1);
      #2 reset = 1;
      #1;
      mreset();
      check_outputs();
      @(posedge clk); #1;
      reset = 0;
      ex_ready = 1;
      instr(7, 6, 0, 16'h7FFF, 0, 1);
      cycle();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
